// File: rtl/qs_srt_pkg.sv
// qs_srt_pkg: shared instruction, ucode and issue-state types for the qs_srt microcode engine
package qs_srt_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_JCC, OP_CALL, OP_RET, OP_AWAIT, OP_EMIT
  } opcode_e;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
  } inst_t;
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic        wr_en;
    logic        is_jump;
    logic        is_call;
    logic        is_ret;
    logic        is_await;
    logic        is_emit;
    logic        invalid_inst;
  } ucode_t;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BR, S_AWAIT, S_EMIT, S_ERR} issue_state_t;
  function automatic logic is_ctrl_flow(ucode_t u);
    return u.is_jump | u.is_ret;
  endfunction
endpackage

// File: rtl/qs_srt_ucode_decoder.sv
// qs_srt_ucode_decoder: combinational instruction to ucode decode
module qs_srt_ucode_decoder
  import qs_srt_pkg::*;
(
  input  inst_t  inst_i,
  output ucode_t ucode_o
);
  always_comb begin
    ucode_o = '{
      op:           inst_i.opcode,
      rd:           inst_i.rd,
      rs:           inst_i.rs,
      rt:           inst_i.rt,
      imm:          inst_i.imm,
      wr_en:        inst_i.opcode inside {OP_ADD, OP_SUB, OP_LD},
      is_jump:      inst_i.opcode inside {OP_JCC, OP_CALL},
      is_call:      inst_i.opcode == OP_CALL,
      is_ret:       inst_i.opcode == OP_RET,
      is_await:     inst_i.opcode == OP_AWAIT,
      is_emit:      inst_i.opcode == OP_EMIT,
      invalid_inst: inst_i.opcode > OP_EMIT
    };
  end
endmodule

// File: rtl/qs_srt_issue_ctrl.sv
// qs_srt_issue_ctrl: PC/fetch/decode/issue control with branch, AWAIT and EMIT handshakes
module qs_srt_issue_ctrl
  import qs_srt_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_vld,
  input  logic [PC_W-1:0] start_pc,
  input  logic            flush,
  output logic            busy,
  output logic            err,
  output logic            imem_ren,
  output logic [PC_W-1:0] imem_raddr,
  input  inst_t           imem_rdata,
  output logic            issue_vld,
  input  logic            issue_rdy,
  output ucode_t          issue_ucode,
  output logic [PC_W-1:0] issue_pc,
  input  logic            br_vld,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            await_rdy,
  input  logic            await_vld,
  output logic            emit_vld,
  input  logic            emit_rdy
);
  issue_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, raddr;
  inst_t           ir_q, dec_in;
  logic            err_q, err_d, rd_q, ren;
  ucode_t          uc;
  // read data is only on the bus in the cycle after the strobe; otherwise replay ir
  assign dec_in = rd_q ? imem_rdata : ir_q;
  qs_srt_ucode_decoder u_dec (.inst_i(dec_in), .ucode_o(uc));
  assign pc_inc      = pc_q + PC_W'(1);
  assign issue_ucode = uc;
  assign issue_pc    = pc_q;
  assign issue_vld   = state_q == S_ISSUE && !uc.invalid_inst && !uc.is_await && !uc.is_emit;
  assign busy        = state_q != S_IDLE;
  assign err         = err_q;
  assign await_rdy   = state_q == S_AWAIT;
  assign emit_vld    = state_q == S_EMIT;
  assign imem_ren    = ren;
  assign imem_raddr  = ren ? raddr : '0;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    ren     = 1'b0;
    raddr   = pc_inc;
    if (flush) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_vld) begin
          ren     = 1'b1;
          raddr   = start_pc;
          pc_d    = start_pc;
          state_d = S_ISSUE;
        end
        S_ISSUE: if (uc.invalid_inst) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (uc.is_await) begin
          state_d = S_AWAIT;
        end else if (uc.is_emit) begin
          state_d = S_EMIT;
        end else if (issue_rdy) begin
          state_d = is_ctrl_flow(uc) ? S_BR : S_ISSUE;
          ren     = !is_ctrl_flow(uc);
          pc_d    = is_ctrl_flow(uc) ? pc_q : pc_inc;
        end
        S_BR: if (br_vld) begin
          ren     = 1'b1;
          raddr   = br_taken ? br_target : pc_inc;
          pc_d    = raddr;
          state_d = S_ISSUE;
        end
        S_AWAIT, S_EMIT: if (state_q == S_AWAIT ? await_vld : emit_rdy) begin
          ren     = 1'b1;
          pc_d    = pc_inc;
          state_d = S_ISSUE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      rd_q    <= ren;
      if (rd_q && !flush) ir_q <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_qs_srt_issue_ctrl.sv
// tb_qs_srt_issue_ctrl: scoreboard bench for the issue controller
module tb_qs_srt_issue_ctrl;
  import qs_srt_pkg::*;
  localparam int PC_W = 10;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      op;
    logic [15:0]     imm;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_vld, flush, issue_rdy, br_vld, br_taken, await_vld, emit_rdy;
  logic [PC_W-1:0] start_pc, br_target, imem_raddr, issue_pc;
  logic busy, err, imem_ren, issue_vld, await_rdy, emit_vld;
  inst_t imem_rdata;
  ucode_t issue_ucode;
  inst_t mem [1024];
  exp_t sb[$];
  exp_t obs[$];
  logic [PC_W-1:0] rd_log[$];
  int obs_rd = 0;
  int n_chk = 0, n_fail = 0;
  qs_srt_issue_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .start_vld(start_vld), .start_pc(start_pc), .flush(flush),
    .busy(busy), .err(err), .imem_ren(imem_ren), .imem_raddr(imem_raddr),
    .imem_rdata(imem_rdata), .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .issue_ucode(issue_ucode), .issue_pc(issue_pc), .br_vld(br_vld), .br_taken(br_taken),
    .br_target(br_target), .await_rdy(await_rdy), .await_vld(await_vld),
    .emit_vld(emit_vld), .emit_rdy(emit_rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_ren) imem_rdata <= mem[imem_raddr];
  always @(negedge clk) if (!rst) begin
    if (imem_ren) rd_log.push_back(imem_raddr);
    if (issue_vld && issue_rdy) obs.push_back('{pc: issue_pc, op: issue_ucode.op, imm: issue_ucode.imm});
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end
  function automatic void put(int a, logic [3:0] op);
    mem[a] = '{opcode: op, rd: 4'(a), rs: 4'd0, rt: 4'd0, imm: 16'(a)};
  endfunction
  function automatic void expect_issue(int a, logic [3:0] op);
    sb.push_back('{pc: PC_W'(a), op: op, imm: 16'(a)});
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic flush_now;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask
  task automatic start_at(int a);
    issue_rdy = 1'b1;
    start_vld = 1'b1;
    start_pc = PC_W'(a);
    tick;
    start_vld = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    smp;
    n_chk++;
    if ({busy, err, issue_vld, imem_ren, await_rdy, emit_vld, imem_raddr, issue_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b err=%b vld=%b ren=%b ardy=%b evld=%b raddr=%h pc=%h, required all 0",
               busy, err, issue_vld, imem_ren, await_rdy, emit_vld, imem_raddr, issue_pc);
    end
    n_chk++;
    if (issue_ucode !== '0) begin
      n_fail++;
      $display("FAIL reset_ucode: got %h, required 0", issue_ucode);
    end
    tick;
  endtask
  task automatic test_straight;
    int base;
    logic ok;
    exp_t ex;
    for (int i = 0; i < 4; i++) begin
      put(16 + i, OP_ADD);
      expect_issue(16 + i, OP_ADD);
    end
    base = rd_log.size();
    issue_rdy = 1'b1;
    start_vld = 1'b1;
    start_pc = 10'h010;
    smp;
    n_chk++;
    if ({imem_ren, imem_raddr} !== {1'b1, 10'h010}) begin
      n_fail++;
      $display("FAIL straight_start_read: got ren=%b addr=%h, required 1/010", imem_ren, imem_raddr);
    end
    tick;
    start_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp;
      n_chk++;
      if ({issue_vld, issue_pc} !== {1'b1, PC_W'(16 + i)}) begin
        n_fail++;
        $display("FAIL straight_issue_pc: got vld=%b pc=%h, required 1/%h", issue_vld, issue_pc, 16 + i);
      end
      tick;
    end
    smp;
    tick;
    smp;
    n_chk++;
    if (await_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL straight_await: got await_rdy=%b, required 1", await_rdy);
    end
    flush_now;
    ok = rd_log.size() - base == 5;
    for (int i = 0; ok && i < 5; i++) ok = rd_log[base + i] == PC_W'(16 + i);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL straight_reads: got %0d reads starting %h, required 5 reads 010..014",
               rd_log.size() - base, rd_log[base]);
    end
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL straight_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL straight_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  task automatic test_backpressure;
    exp_t ex;
    for (int i = 0; i < 6; i++) begin
      put(64 + i, OP_ADD);
      expect_issue(64 + i, OP_ADD);
    end
    start_at(64);
    for (int i = 0; i < 2; i++) begin
      smp;
      tick;
    end
    issue_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      n_chk++;
      if ({issue_vld, issue_pc, issue_ucode.op, issue_ucode.imm, imem_ren} !==
          {1'b1, 10'h042, 4'(OP_ADD), 16'h0042, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold: got vld=%b pc=%h op=%h imm=%h ren=%b, required 1/042/1/0042/0",
                 issue_vld, issue_pc, issue_ucode.op, issue_ucode.imm, imem_ren);
      end
      tick;
    end
    issue_rdy = 1'b1;
    smp;
    n_chk++;
    if ({issue_vld, issue_pc, imem_ren, imem_raddr} !== {1'b1, 10'h042, 1'b1, 10'h043}) begin
      n_fail++;
      $display("FAIL bp_resume: got vld=%b pc=%h ren=%b addr=%h, required 1/042/1/043",
               issue_vld, issue_pc, imem_ren, imem_raddr);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      smp;
      tick;
    end
    flush_now;
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL bp_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL bp_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  task automatic run_branch(int pc, logic [3:0] op, logic taken, int tgt, int nxt);
    int base;
    exp_t ex;
    put(pc, op);
    put(nxt, OP_ADD);
    put(nxt + 1, OP_AWAIT);
    expect_issue(pc, op);
    expect_issue(nxt, OP_ADD);
    base = rd_log.size();
    start_at(pc);
    smp;
    n_chk++;
    if ({issue_vld, issue_pc, imem_ren} !== {1'b1, PC_W'(pc), 1'b0}) begin
      n_fail++;
      $display("FAIL br_issue: got vld=%b pc=%h ren=%b, required 1/%h/0", issue_vld, issue_pc, imem_ren, pc);
    end
    tick;
    smp;
    n_chk++;
    if ({issue_vld, imem_ren, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL br_wait: got vld=%b ren=%b busy=%b, required 0/0/1", issue_vld, imem_ren, busy);
    end
    tick;
    br_vld = 1'b1;
    br_taken = taken;
    br_target = PC_W'(tgt);
    smp;
    n_chk++;
    if ({imem_ren, imem_raddr} !== {1'b1, PC_W'(nxt)}) begin
      n_fail++;
      $display("FAIL br_redirect: got ren=%b addr=%h, required 1/%h", imem_ren, imem_raddr, nxt);
    end
    tick;
    br_vld = 1'b0;
    br_taken = 1'b0;
    smp;
    n_chk++;
    if ({issue_vld, issue_pc} !== {1'b1, PC_W'(nxt)}) begin
      n_fail++;
      $display("FAIL br_next_issue: got vld=%b pc=%h, required 1/%h", issue_vld, issue_pc, nxt);
    end
    tick;
    smp;
    tick;
    flush_now;
    n_chk++;
    if (rd_log.size() - base != 3 || rd_log[base] != PC_W'(pc) || rd_log[base + 1] != PC_W'(nxt) ||
        rd_log[base + 2] != PC_W'(nxt + 1)) begin
      n_fail++;
      $display("FAIL br_reads: got %0d reads, second %h, required 3 reads %h/%h/%h",
               rd_log.size() - base, rd_log[base + 1], pc, nxt, nxt + 1);
    end
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL br_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL br_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  task automatic test_branch;
    run_branch('h020, OP_JCC, 1'b1, 'h100, 'h100);
    run_branch('h020, OP_JCC, 1'b0, 'h100, 'h021);
    run_branch('h060, OP_CALL, 1'b1, 'h070, 'h070);
    run_branch('h080, OP_RET, 1'b1, 'h090, 'h090);
  endtask
  task automatic test_await_emit;
    exp_t ex;
    put('h30, OP_AWAIT);
    put('h31, OP_EMIT);
    put('h32, OP_ADD);
    put('h33, OP_AWAIT);
    expect_issue('h32, OP_ADD);
    start_at('h30);
    smp;
    n_chk++;
    if ({issue_vld, await_rdy, emit_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL ae_detect_await: got vld=%b ardy=%b evld=%b, required 000", issue_vld, await_rdy, emit_vld);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      br_vld = i == 1;
      emit_rdy = i == 2;
      smp;
      n_chk++;
      if ({await_rdy, imem_ren, issue_vld} !== 3'b100) begin
        n_fail++;
        $display("FAIL ae_await_hold: got ardy=%b ren=%b vld=%b, required 100", await_rdy, imem_ren, issue_vld);
      end
      tick;
    end
    br_vld = 1'b0;
    emit_rdy = 1'b0;
    await_vld = 1'b1;
    smp;
    n_chk++;
    if ({await_rdy, imem_ren, imem_raddr} !== {1'b1, 1'b1, 10'h031}) begin
      n_fail++;
      $display("FAIL ae_await_release: got ardy=%b ren=%b addr=%h, required 1/1/031", await_rdy, imem_ren, imem_raddr);
    end
    tick;
    smp;
    n_chk++;
    if ({issue_vld, emit_vld, await_rdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL ae_detect_emit: got vld=%b evld=%b ardy=%b, required 000", issue_vld, emit_vld, await_rdy);
    end
    tick;
    smp;
    n_chk++;
    if ({emit_vld, imem_ren} !== 2'b10) begin
      n_fail++;
      $display("FAIL ae_emit_hold: got evld=%b ren=%b, required 10", emit_vld, imem_ren);
    end
    tick;
    await_vld = 1'b0;
    emit_rdy = 1'b1;
    smp;
    n_chk++;
    if ({emit_vld, imem_ren, imem_raddr} !== {1'b1, 1'b1, 10'h032}) begin
      n_fail++;
      $display("FAIL ae_emit_release: got evld=%b ren=%b addr=%h, required 1/1/032", emit_vld, imem_ren, imem_raddr);
    end
    tick;
    emit_rdy = 1'b0;
    smp;
    n_chk++;
    if ({issue_vld, issue_pc, emit_vld} !== {1'b1, 10'h032, 1'b0}) begin
      n_fail++;
      $display("FAIL ae_next_issue: got vld=%b pc=%h evld=%b, required 1/032/0", issue_vld, issue_pc, emit_vld);
    end
    tick;
    smp;
    tick;
    flush_now;
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL ae_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL ae_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  task automatic test_invalid;
    exp_t ex;
    put(5, 4'hF);
    start_at(5);
    smp;
    n_chk++;
    if ({issue_vld, err, imem_ren} !== 3'b000) begin
      n_fail++;
      $display("FAIL inv_detect: got vld=%b err=%b ren=%b, required 000", issue_vld, err, imem_ren);
    end
    tick;
    smp;
    n_chk++;
    if ({err, busy, issue_vld, await_rdy, emit_vld, imem_ren} !== 6'b110000) begin
      n_fail++;
      $display("FAIL inv_err: got err=%b busy=%b vld=%b ardy=%b evld=%b ren=%b, required 110000",
               err, busy, issue_vld, await_rdy, emit_vld, imem_ren);
    end
    n_chk++;
    if (dut.state_q !== S_ERR) begin
      n_fail++;
      $display("FAIL inv_state: got %0d, required %0d", dut.state_q, S_ERR);
    end
    tick;
    start_vld = 1'b1;
    start_pc = 10'h010;
    smp;
    n_chk++;
    if ({imem_ren, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL inv_start_ignored: got ren=%b err=%b, required 0/1", imem_ren, err);
    end
    tick;
    flush = 1'b1;
    smp;
    n_chk++;
    if (imem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_flush_start: got ren=%b, required 0", imem_ren);
    end
    tick;
    flush = 1'b0;
    start_vld = 1'b0;
    smp;
    n_chk++;
    if ({err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL inv_cleared: got err=%b busy=%b, required 00", err, busy);
    end
    tick;
    for (int i = 0; i < 4; i++) expect_issue(16 + i, OP_ADD);
    start_at(16);
    smp;
    n_chk++;
    if ({issue_vld, issue_pc, err} !== {1'b1, 10'h010, 1'b0}) begin
      n_fail++;
      $display("FAIL inv_restart: got vld=%b pc=%h err=%b, required 1/010/0", issue_vld, issue_pc, err);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      smp;
      tick;
    end
    flush_now;
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL inv_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL inv_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  task automatic test_wrap_flush;
    exp_t ex;
    put(1023, OP_ADD);
    put(0, OP_AWAIT);
    put('h200, OP_JCC);
    expect_issue(1023, OP_ADD);
    expect_issue('h200, OP_JCC);
    start_at(1023);
    smp;
    n_chk++;
    if ({issue_vld, issue_pc, imem_ren, imem_raddr} !== {1'b1, 10'h3FF, 1'b1, 10'h000}) begin
      n_fail++;
      $display("FAIL wrap_read: got vld=%b pc=%h ren=%b addr=%h, required 1/3ff/1/000",
               issue_vld, issue_pc, imem_ren, imem_raddr);
    end
    tick;
    smp;
    n_chk++;
    if ({issue_vld, issue_pc} !== {1'b0, 10'h000}) begin
      n_fail++;
      $display("FAIL wrap_pc: got vld=%b pc=%h, required 0/000", issue_vld, issue_pc);
    end
    tick;
    flush_now;
    start_at('h200);
    smp;
    tick;
    br_vld = 1'b1;
    br_taken = 1'b1;
    br_target = 10'h300;
    flush = 1'b1;
    smp;
    n_chk++;
    if ({imem_ren, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_br_read: got ren=%b busy=%b, required 0/1", imem_ren, busy);
    end
    tick;
    flush = 1'b0;
    br_vld = 1'b0;
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp;
      n_chk++;
      if ({busy, imem_ren, issue_vld} !== 3'b000) begin
        n_fail++;
        $display("FAIL flush_br_idle: got busy=%b ren=%b vld=%b, required 000", busy, imem_ren, issue_vld);
      end
      tick;
    end
    n_chk++;
    if (obs.size() - obs_rd != sb.size()) begin
      n_fail++;
      $display("FAIL wrap_sb_count: got %0d issues, required %0d", obs.size() - obs_rd, sb.size());
    end
    while (sb.size() > 0 && obs_rd < obs.size()) begin
      ex = sb.pop_front();
      n_chk++;
      if (obs[obs_rd] !== ex) begin
        n_fail++;
        $display("FAIL wrap_sb: got %h, required %h", obs[obs_rd], ex);
      end
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs.size();
  endtask
  initial begin
    {start_vld, flush, issue_rdy, br_vld, br_taken, await_vld, emit_rdy} = '0;
    start_pc = '0;
    br_target = '0;
    for (int i = 0; i < 1024; i++) put(i, OP_AWAIT);
    test_reset;
    test_straight;
    test_backpressure;
    test_branch;
    test_await_emit;
    test_invalid;
    test_wrap_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
